// File: rtl/sim_uart_in_responder.sv
// Purpose: byte FIFO that serves a simulated UART-in read port, with an optional idle gap after each delivered byte.
// Latency: a pushed byte becomes readable on the cycle after its push. Read data is returned in the same cycle as the strobe.
// Backpressure: push_ready is low while the FIFO is full. A read with nothing deliverable returns EMPTY_CH and counts a miss.
module sim_uart_in_responder #(
  parameter int         DEPTH    = 16,
  parameter int         GAP      = 0,
  parameter logic [7:0] EMPTY_CH = 8'hff
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_valid,
  input  logic [7:0]             push_ch,
  output logic                   push_ready,
  input  logic                   difftest_uart_in_valid,
  output logic [7:0]             difftest_uart_in_ch,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            miss_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {IDLE, READY, HOLD} state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   rptr;
  logic [AW-1:0]   wptr;
  logic [GW-1:0]   gap_cnt;
  logic            do_push;
  logic            do_pop;
  logic            deliverable;
  logic [LW-1:0]   level_nxt;

  // Handshakes and output data come only from registers; the read strobe never feeds the returned byte.
  assign push_ready          = (level != LW'(DEPTH));
  assign deliverable         = (state == READY);
  assign do_push             = push_valid && push_ready;
  assign do_pop              = difftest_uart_in_valid && deliverable;
  assign level_nxt           = level + LW'(do_push) - LW'(do_pop);
  assign difftest_uart_in_ch = deliverable ? mem[rptr] : EMPTY_CH;

  // Storage is not reset; occupancy tracking guarantees stale entries are never read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= push_ch;
  end

  // Pointers, occupancy and the saturating miss counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rptr     <= '0;
      wptr     <= '0;
      level    <= '0;
      miss_cnt <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      level <= level_nxt;
      if (difftest_uart_in_valid && !deliverable && (miss_cnt != 16'hffff))
        miss_cnt <= miss_cnt + 16'd1;
    end
  end

  // Delivery FSM: a pop with a nonzero gap holds off further reads for GAP cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else if (do_pop && (GAP > 0)) begin
      state   <= HOLD;
      gap_cnt <= GW'(GAP);
    end else if (state == HOLD) begin
      gap_cnt <= gap_cnt - GW'(1);
      if (gap_cnt == GW'(1))
        state <= (level_nxt != '0) ? READY : IDLE;
    end else begin
      state <= (level_nxt != '0) ? READY : IDLE;
    end
  end

endmodule

// File: doc/sim_uart_in_responder.md
SIM_UART_IN_RESPONDER -- requirements
Module: sim_uart_in_responder

Interface
REQ-001 Parameter DEPTH, default 16: FIFO entries; power of two, >= 2.
REQ-002 Parameter GAP, default 0: minimum idle cycles enforced after each delivered byte.
REQ-003 Parameter EMPTY_CH, default 8'hff: byte returned when no byte is deliverable.
REQ-004 clock  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 push_valid  input  1  host offers a byte this cycle.
REQ-007 push_ch  input  8  host byte.
REQ-008 push_ready  output  1  FIFO can accept a byte.
REQ-009 difftest_uart_in_valid  input  1  DUT read strobe; one byte consumed per high cycle.
REQ-010 difftest_uart_in_ch  output  8  byte returned to the DUT in the same cycle as the strobe.
REQ-011 level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 miss_cnt  output  16  count of DUT reads that received EMPTY_CH.

Function
REQ-013 The FIFO shall use read/write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0, plus an occupancy counter.
REQ-014 push_ready shall equal (level != DEPTH), combinational from registers, with no dependence on the DUT strobe.
REQ-015 A push shall occur on a posedge where push_valid && push_ready: write push_ch at wptr, then increment wptr.
REQ-016 The state machine shall have three states: IDLE (level==0), READY (level>0 and gap_cnt==0), and HOLD (gap_cnt>0).
REQ-017 deliverable shall be (state==READY).
REQ-018 difftest_uart_in_ch shall be the FIFO head when deliverable, else EMPTY_CH.
REQ-019 difftest_uart_in_ch shall be combinational from registers only, with no path from difftest_uart_in_valid.
REQ-020 A pop shall occur on a posedge where difftest_uart_in_valid && deliverable: increment rptr.
REQ-021 On a pop with GAP>0, gap_cnt shall load GAP and the state shall go to HOLD.
REQ-022 On a pop with GAP==0, there shall be no HOLD; back-to-back pops on consecutive cycles are permitted.
REQ-023 In HOLD, gap_cnt shall decrement once per cycle.
REQ-024 When HOLD reaches 0, the next state shall be READY if level>0, else IDLE.
REQ-025 Pushes shall be accepted in every state.
REQ-026 IDLE shall go to READY on the cycle after the first accepted push.
REQ-027 A push and a pop in the same cycle shall leave level unchanged.
REQ-028 level shall increment on push only and decrement on pop only.
REQ-029 Push to an empty FIFO: the DUT cannot read the byte in the same cycle (no bypass); a same-cycle strobe returns EMPTY_CH.
REQ-030 Full FIFO: push is refused and data is preserved; a same-cycle pop frees the entry for the next cycle only.
REQ-031 miss_cnt shall increment on every cycle with difftest_uart_in_valid && !deliverable, in IDLE and in HOLD.
REQ-032 miss_cnt shall saturate at 16'hffff.
REQ-033 If difftest_uart_in_valid is held high continuously, one byte shall be delivered every GAP+1 cycles while data is available.

Reset
REQ-034 While reset is high, state shall be IDLE; rptr, wptr, level, gap_cnt and miss_cnt shall be 0.
REQ-035 While reset is high, push_ready shall be 1 and difftest_uart_in_ch shall be EMPTY_CH.
REQ-036 Reset asserted mid-operation shall take effect immediately and asynchronously, discarding all queued bytes and any HOLD in progress.
REQ-037 FIFO storage need not be reset; no byte written before reset shall ever be delivered after it.
REQ-038 The first push shall be accepted at the first posedge after reset deasserts.

Verification
REQ-039 GAP=0: push 'h','i' on consecutive cycles, then strobe for 3 cycles -> ch = 8'h68, 8'h69, 8'hff; level 2->0; miss_cnt=1.
REQ-040 GAP=3: push 4 bytes, hold strobe high for 12 cycles -> bytes delivered at cycles 0,4,8; other 9 strobe cycles return 8'hff; miss_cnt=9; level=1.
REQ-041 DEPTH=16: push 17 bytes with no reads -> push_ready drops after the 16th; 17th byte held off; level=16.
REQ-042 DEPTH=16, full: push and strobe in the same cycle -> first byte out, push refused, push_ready=1 next cycle, level=15.
REQ-043 Empty FIFO: push 8'h41 and strobe in the same cycle -> ch=8'hff and miss_cnt=1; strobe next cycle -> ch=8'h41.
REQ-044 3 bytes queued, GAP=5, reset asserted in HOLD -> level=0 and ch=8'hff immediately; after release, strobe returns 8'hff and miss_cnt counts from 0.
